ysyx_22040386_lsu: RTL
======================

// Module: ysyx_22040386_lsu
// PURPOSE
//  Parametrised load/store unit between the EXU and a handshaked data-memory port.
//  Accepts one access at a time and drives the byte-lane write mask.
//  Handles load alignment and sign/zero extension, with a multi-cycle memory
//  handshake and a timeout. Replaces the single-cycle DPI memory stage.
// PARAMETERS
//  DATA_W   64   data/bus width, 32 or 64; LANES = DATA_W/8
//  ADDR_W   64   address width
//  TIMEOUT  256  max cycles waiting in REQ+RESP before error; 0 = no timeout
// PORTS
//  clk            in   1        clock, all state on rising edge
//  rst            in   1        asynchronous, active-high reset
//  req_valid      in   1        EXU access request
//  req_ready      out  1        LSU can accept (IDLE only)
//  req_wen        in   1        1 = store, 0 = load
//  req_size       in   3        [1:0] b/h/w/d, [2] = 1 unsigned load; d illegal if DATA_W=32
//  req_addr       in   ADDR_W   byte address
//  req_wdata      in   DATA_W   store data, right-aligned
//  resp_valid     out  1        one-cycle completion pulse
//  resp_rdata     out  DATA_W   extended load data; 0 for stores and errors
//  resp_err       out  1        misaligned / bus error / timeout, valid with resp_valid
//  mem_req_valid  out  1        memory request
//  mem_req_ready  in   1        memory accepts
//  mem_req_wen    out  1        store beat
//  mem_req_addr   out  ADDR_W   lane-aligned address (low log2(LANES) bits 0)
//  mem_req_wdata  out  DATA_W   lane-shifted write data
//  mem_req_wmask  out  LANES    byte enables (0 on loads)
//  mem_rsp_valid  in   1        response beat
//  mem_rsp_rdata  in   DATA_W   raw lane data
//  mem_rsp_err    in   1        bus error
// BEHAVIOUR
//  Reset: state IDLE, req_ready=1, all other outputs 0, timeout counter 0.
//  FSM: IDLE -> REQ -> RESP -> DONE -> IDLE; IDLE -> DONE directly on a misaligned request.
//  IDLE: req_valid&req_ready captures wen/size/addr/wdata.
//  REQ: mem_req_* stable, mem_req_valid=1 until mem_req_ready.
//  RESP: waits for mem_rsp_valid and registers the extended data and err.
//  DONE: resp_valid=1 for exactly one cycle.
//  Min latency: accept at T, resp_valid at T+3 with zero-wait memory.
//  Mask: size lanes {1,2,4,8} ones shifted left by addr[log2(LANES)-1:0].
//  Wdata shifted by 8*offset.
//  Load: rdata shifted right by 8*offset, truncated to size.
//  Load extension: sign-extended if size[2]=0, zero-extended otherwise.
//  Misaligned (addr mod size != 0): no memory traffic; DONE with resp_err=1.
//  Timeout: counter runs in REQ/RESP and clears in IDLE. Reaching TIMEOUT -> DONE, err=1.
//  Stray mem_rsp_valid in IDLE/REQ/DONE is ignored; mem_rsp_err forces err=1 and rdata=0.
//  req_valid during a busy access is held off (req_ready=0); nothing is dropped.
//  Reset mid-access aborts immediately and does not complete the access.
// CONFIGURATION
//  YSYX_22040386_LSU_MISALIGN_EN defined: misaligned accesses are legal.
//  - An access inside one lane word is a single beat.
//  - An access crossing a lane-word boundary is two beats: addr, then addr+LANES.
//  - The two beats use the low and high halves of a 2*LANES shifted mask/data.
//  - Load data from both beats is merged before extension.
//  - FSM adds REQ2/RESP2 states; error on either beat sets err.
//  - Each beat has its own timeout window.
//  Undefined: misaligned requests are rejected with resp_err=1 (see BEHAVIOUR).
// STRUCTURE
//  ysyx_22040386_lsu_pkg: size encodings (SZ_B/H/W/D), state enum, LANES/OFF_W localparams.
//  Sub-module ysyx_22040386_lsu_align, combinational:
//  - inputs size, offset, wdata, rdata (2*DATA_W when the macro is on)
//  - outputs wmask, shifted wdata, extended rdata
// TESTING
//  lb addr 0x8000_0003, mem word 0x0000_0000_8000_0000 -> rdata 0xFFFF_FFFF_FFFF_FF80, T+3.
//  sh addr 0x8000_0006, wdata 0xBEEF -> wmask 0xC0, mem_req_wdata 0xBEEF_0000_0000_0000.
//  lwu addr 0x8000_0002, macro off -> no mem_req_valid, resp_err=1, rdata 0.
//  ld addr 0x8000_0004, macro on -> beats at 0x8000_0000 (mask 0xF0) and 0x8000_0008 (mask 0x0F).
//    Merged rdata is correct.
//  mem_req_ready held 0, TIMEOUT=16 -> resp_valid with err=1 at cycle 16 after REQ entry.
//  rst pulse in RESP, then stray mem_rsp_valid -> state IDLE, no resp_valid.

Source files
------------

// File: rtl/ysyx_22040386_lsu_pkg.sv
// Shared definitions for the LSU: access-size encodings, FSM states and default lane geometry.
package ysyx_22040386_lsu_pkg;

    localparam int DEF_DATA_W = 64;
    localparam int LANES      = DEF_DATA_W / 8;
    localparam int OFF_W      = $clog2(LANES);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RESP,
        S_DONE,
        S_REQ2,
        S_RESP2
    } lsu_state_e;

endpackage

// File: rtl/ysyx_22040386_lsu_align.sv
// Combinational lane alignment: byte mask and write-data shift for stores,
// right shift plus sign/zero extension for loads. RW is 2*DATA_W when two-beat accesses exist.
module ysyx_22040386_lsu_align
    import ysyx_22040386_lsu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int RW     = DATA_W
) (
    input  logic [2:0]                  size,
    input  logic [$clog2(DATA_W/8)-1:0] offset,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [RW-1:0]               rdata,
    output logic [RW/8-1:0]             wmask,
    output logic [RW-1:0]               wdata_sh,
    output logic [DATA_W-1:0]           rdata_ext
);

    localparam int MW = RW / 8;

    logic [MW-1:0]            base_mask;
    logic [RW-1:0]            rd_sh;
    logic [DATA_W-1:0]        rd_lo;
    logic [DATA_W-1:0]        rd_top;
    logic signed [DATA_W-1:0] rd_sext;
    int unsigned              nbits;
    int unsigned              pad;

    always_comb begin
        case (size[1:0])
            SZ_B:    base_mask = MW'(8'h01);
            SZ_H:    base_mask = MW'(8'h03);
            SZ_W:    base_mask = MW'(8'h0f);
            default: base_mask = MW'(8'hff);
        endcase
    end

    assign wmask    = base_mask << offset;
    assign wdata_sh = RW'(wdata) << {offset, 3'b000};
    assign rd_sh    = rdata >> {offset, 3'b000};
    assign rd_lo    = rd_sh[DATA_W-1:0];

    // Move the field to the top, then shift back down arithmetically or logically.
    always_comb begin
        nbits     = 32'd8 << size[1:0];
        pad       = 0;
        rd_top    = rd_lo;
        rd_sext   = rd_lo;
        rdata_ext = rd_lo;
        if (nbits < DATA_W) begin
            pad       = DATA_W - nbits;
            rd_top    = rd_lo << pad;
            rd_sext   = $signed(rd_top) >>> pad;
            rdata_ext = size[2] ? (rd_top >> pad) : rd_sext;
        end
    end

endmodule

// File: rtl/ysyx_22040386_lsu.sv
// Load/store unit with one outstanding access, handshaked memory port and per-access timeout.
// Define YSYX_22040386_LSU_MISALIGN_EN to split lane-crossing accesses into two beats.
module ysyx_22040386_lsu
    import ysyx_22040386_lsu_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = 64,
    parameter int TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [2:0]            req_size,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic                  mem_req_wen,
    output logic [ADDR_W-1:0]     mem_req_addr,
    output logic [DATA_W-1:0]     mem_req_wdata,
    output logic [DATA_W/8-1:0]   mem_req_wmask,
    input  logic                  mem_rsp_valid,
    input  logic [DATA_W-1:0]     mem_rsp_rdata,
    input  logic                  mem_rsp_err
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFFW  = $clog2(BYTES);
    localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
`ifdef YSYX_22040386_LSU_MISALIGN_EN
    localparam int RW = 2 * DATA_W;
`else
    localparam int RW = DATA_W;
`endif
    localparam int MW = RW / 8;

    lsu_state_e        state, state_d;
    logic              wen_q;
    logic [2:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [TW-1:0]     cnt;
    logic [MW-1:0]     wmask_w;
    logic [RW-1:0]     wdata_w;
    logic [RW-1:0]     rd_in;
    logic [DATA_W-1:0] rext;
    logic [ADDR_W-1:0] base_addr;
    logic [2:0]        amask;
    logic              illegal;
    logic              bad;
    logic              tmo;
`ifdef YSYX_22040386_LSU_MISALIGN_EN
    logic              cross;
    logic              cross_q;
    logic [DATA_W-1:0] raw_lo;
`endif

    always_comb begin
        case (req_size[1:0])
            SZ_B:    amask = 3'b000;
            SZ_H:    amask = 3'b001;
            SZ_W:    amask = 3'b011;
            default: amask = 3'b111;
        endcase
        illegal = (DATA_W == 32) && (req_size[1:0] == SZ_D);
    end

`ifdef YSYX_22040386_LSU_MISALIGN_EN
    assign cross = (int'(req_addr[OFFW-1:0]) + (1 << req_size[1:0])) > BYTES;
    assign bad   = illegal;
    assign rd_in = (state == S_RESP2) ? {mem_rsp_rdata, raw_lo} : {{DATA_W{1'b0}}, mem_rsp_rdata};
    assign mem_req_addr  = (state == S_REQ2) ? base_addr + ADDR_W'(BYTES) : base_addr;
    assign mem_req_wdata = (state == S_REQ2) ? wdata_w[RW-1:DATA_W] : wdata_w[DATA_W-1:0];
    assign mem_req_wmask = !wen_q ? '0 :
                           (state == S_REQ2) ? wmask_w[MW-1:BYTES] : wmask_w[BYTES-1:0];
`else
    assign bad   = (|(req_addr[2:0] & amask)) | illegal;
    assign rd_in = mem_rsp_rdata;
    assign mem_req_addr  = base_addr;
    assign mem_req_wdata = wdata_w;
    assign mem_req_wmask = wen_q ? wmask_w : '0;
`endif

    assign base_addr   = {addr_q[ADDR_W-1:OFFW], {OFFW{1'b0}}};
    assign mem_req_wen = wen_q;
    assign tmo         = (TIMEOUT != 0) && (cnt == '0);
    assign resp_rdata  = resp_valid ? rdata_q : '0;
    assign resp_err    = resp_valid & err_q;

    ysyx_22040386_lsu_align #(.DATA_W(DATA_W), .RW(RW)) u_align (
        .size      (size_q),
        .offset    (addr_q[OFFW-1:0]),
        .wdata     (wdata_q),
        .rdata     (rd_in),
        .wmask     (wmask_w),
        .wdata_sh  (wdata_w),
        .rdata_ext (rext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d       = state;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = bad ? S_DONE : S_REQ;
            end
            S_REQ, S_REQ2: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready)  state_d = (state == S_REQ) ? S_RESP : S_RESP2;
                else if (tmo)       state_d = S_DONE;
            end
            S_RESP: begin
                if (mem_rsp_valid) begin
                    state_d = S_DONE;
`ifdef YSYX_22040386_LSU_MISALIGN_EN
                    if (cross_q && !mem_rsp_err) state_d = S_REQ2;
`endif
                end else if (tmo) begin
                    state_d = S_DONE;
                end
            end
            S_RESP2: if (mem_rsp_valid || tmo) state_d = S_DONE;
            S_DONE: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Down-counter loaded per beat; reaching zero while still waiting is a timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wen_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
`ifdef YSYX_22040386_LSU_MISALIGN_EN
            cross_q <= 1'b0;
            raw_lo  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (req_valid) begin
                        wen_q   <= req_wen;
                        size_q  <= req_size;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        rdata_q <= '0;
                        err_q   <= bad;
                        cnt     <= TLOAD;
`ifdef YSYX_22040386_LSU_MISALIGN_EN
                        cross_q <= cross;
`endif
                    end
                end
                S_REQ, S_REQ2: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    if (!mem_req_ready && tmo) err_q <= 1'b1;
                end
                S_RESP, S_RESP2: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    if (mem_rsp_valid) begin
                        if (mem_rsp_err) begin
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
`ifdef YSYX_22040386_LSU_MISALIGN_EN
                        else if (state == S_RESP && cross_q) begin
                            raw_lo <= mem_rsp_rdata;
                            cnt    <= TLOAD;
                        end
`endif
                        else if (!wen_q) begin
                            rdata_q <= rext;
                        end
                    end else if (tmo) begin
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
